// File: rtl/switch_stm_demux_pkg.sv
// Shared definitions for the switch_stm_demux stream demultiplexer.
//   min_sel_width : smallest legal sel width for a given output count
//   drop_cnt_max  : all-ones value of a counter of the given width
//   RST_DATA_BIT  : fill bit for payload registers after reset
package switch_stm_demux_pkg;

  function automatic int min_sel_width(input int n_outputs);
    return (n_outputs <= 2) ? 1 : $clog2(n_outputs);
  endfunction

  function automatic logic [63:0] drop_cnt_max(input int width);
    return (64'd1 << width) - 64'd1;
  endfunction

  localparam logic RST_DATA_BIT = 1'b0;

endpackage

// File: rtl/switch_stm_demux_if.sv
// Bus bundle for switch_stm_demux.
//   din_*   : single producer stream (data, sel, vld, rd)
//   dout_*  : OUTPUTS consumer streams, payload i at [i*DATA_WIDTH +: DATA_WIDTH]
//   drop_*  : saturating drop counter and its synchronous clear
// slave is the demux side, master is the producer/consumer side.
interface switch_stm_demux_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int OUTPUTS        = 3,
  parameter int SEL_WIDTH      = 3,
  parameter int DROP_CNT_WIDTH = 8
);
  logic [DATA_WIDTH-1:0]         din_data;
  logic [SEL_WIDTH-1:0]          din_sel;
  logic                          din_vld;
  logic                          din_rd;
  logic [OUTPUTS*DATA_WIDTH-1:0] dout_data;
  logic [OUTPUTS-1:0]            dout_vld;
  logic [OUTPUTS-1:0]            dout_rd;
  logic [DROP_CNT_WIDTH-1:0]     drop_cnt;
  logic                          drop_clr;

  modport slave (
    input  din_data, din_sel, din_vld, dout_rd, drop_clr,
    output din_rd, dout_data, dout_vld, drop_cnt
  );

  modport master (
    output din_data, din_sel, din_vld, dout_rd, drop_clr,
    input  din_rd, dout_data, dout_vld, drop_cnt
  );
endinterface

// File: rtl/switch_stm_demux_stream_reg_slice.sv
// stream_reg_slice: one-entry registered stream stage.
//   i_load/i_data : write a new beat (caller guarantees o_free)
//   i_rd          : downstream ready
//   o_vld/o_data  : registered output beat
//   o_free        : slot can take a beat this cycle (empty or draining)
// A load in the same cycle as a drain replaces the beat and keeps o_vld high,
// which gives one beat per cycle through the slot.
module stream_reg_slice
  import switch_stm_demux_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_rd,
  output logic                  o_vld,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_free
);
  logic                  r_vld;
  logic [DATA_WIDTH-1:0] r_data;

  assign o_vld  = r_vld;
  assign o_data = r_data;
  assign o_free = !r_vld || i_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= 1'b0;
      r_data <= {DATA_WIDTH{RST_DATA_BIT}};
    end else if (i_load) begin
      r_vld  <= 1'b1;
      r_data <= i_data;
    end else if (i_rd) begin
      r_vld  <= 1'b0;
    end
  end
endmodule

// File: rtl/switch_stm_demux.sv
// switch_stm_demux: routes each input beat to the output named by its sel.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : switch_stm_demux_if.slave (din stream, OUTPUTS dout streams,
//                drop counter and clear)
// Beats whose sel has no output are accepted unconditionally and counted in a
// saturating drop counter. Each output sits behind its own register slice, so a
// stalled output only holds up beats addressed to it.
module switch_stm_demux
  import switch_stm_demux_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int OUTPUTS        = 3,
  parameter int SEL_WIDTH      = 3,
  parameter int DROP_CNT_WIDTH = 8
) (
  input logic                clk,
  input logic                rst_n,
  switch_stm_demux_if.slave  bus
);
  localparam logic [DROP_CNT_WIDTH-1:0] DROP_CNT_MAX =
    DROP_CNT_WIDTH'(drop_cnt_max(DROP_CNT_WIDTH));

  logic [OUTPUTS-1:0]    w_hit;
  logic [OUTPUTS-1:0]    w_free;
  logic [OUTPUTS-1:0]    w_load;
  logic [OUTPUTS-1:0]    w_vld;
  logic [DATA_WIDTH-1:0] w_data [OUTPUTS];
  logic                  w_legal;
  logic                  w_drop;
  logic [DROP_CNT_WIDTH-1:0] r_drop_cnt;

  assign w_legal = (int'(bus.din_sel) < OUTPUTS);

  genvar gi;
  generate
    for (gi = 0; gi < OUTPUTS; gi++) begin : g_out
      assign w_hit[gi]  = (bus.din_sel == SEL_WIDTH'(gi));
      assign w_load[gi] = bus.din_vld && w_hit[gi] && w_free[gi];

      stream_reg_slice #(.DATA_WIDTH(DATA_WIDTH)) u_slice (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load[gi]),
        .i_data (bus.din_data),
        .i_rd   (bus.dout_rd[gi]),
        .o_vld  (w_vld[gi]),
        .o_data (w_data[gi]),
        .o_free (w_free[gi])
      );

      assign bus.dout_data[gi*DATA_WIDTH +: DATA_WIDTH] = w_data[gi];
    end
  endgenerate

  assign bus.dout_vld = w_vld;
  // Ready is a function of sel and slot state only; din_vld never enters it.
  assign bus.din_rd   = w_legal ? |(w_hit & w_free) : 1'b1;
  assign w_drop       = bus.din_vld && !w_legal;
  assign bus.drop_cnt = r_drop_cnt;

  // Clear wins over the old value but a drop in the same cycle still counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (bus.drop_clr) begin
      r_drop_cnt <= w_drop ? DROP_CNT_WIDTH'(1) : '0;
    end else if (w_drop && (r_drop_cnt != DROP_CNT_MAX)) begin
      r_drop_cnt <= r_drop_cnt + DROP_CNT_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_switch_stm_demux.sv
// Scoreboard bench for switch_stm_demux: directed phases followed by random
// traffic; a negedge monitor predicts every accepted beat into per-output
// queues and checks each delivered beat, din_rd and the drop counter.
module tb_switch_stm_demux;
  localparam int DW = 8;
  localparam int NO = 3;
  localparam int SW = 3;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  switch_stm_demux_if #(.DATA_WIDTH(DW), .OUTPUTS(NO), .SEL_WIDTH(SW),
                        .DROP_CNT_WIDTH(CW)) bus ();

  switch_stm_demux #(.DATA_WIDTH(DW), .OUTPUTS(NO), .SEL_WIDTH(SW),
                     .DROP_CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] exp_q [NO][$];
  int            m_drop = 0;
  logic          prev_out_stall [NO];
  logic [DW-1:0] prev_out_data  [NO];
  logic          prev_in_stall  = 1'b0;
  logic [SW-1:0] prev_sel;
  logic [DW-1:0] prev_din;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] out_data(input int i);
    logic [NO*DW-1:0] all;
    all = bus.dout_data;
    return all[i*DW +: DW];
  endfunction

  // Monitor: outputs and ready are checked against the stream rules, then
  // the beat about to transfer on the coming edge is added to the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NO; i++) prev_out_stall[i] = 1'b0;
      prev_in_stall = 1'b0;
    end else begin
      int  s;
      logic exp_rd;
      for (int i = 0; i < NO; i++) begin
        if (prev_out_stall[i]) begin
          check($sformatf("hold_vld%0d", i), 64'(bus.dout_vld[i]), 64'd1);
          check($sformatf("hold_data%0d", i), 64'(out_data(i)), 64'(prev_out_data[i]));
        end
        if (bus.dout_vld[i] && bus.dout_rd[i]) begin
          if (exp_q[i].size() == 0) begin
            check($sformatf("unexpected_out%0d", i), 64'(out_data(i)), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            logic [DW-1:0] e;
            e = exp_q[i].pop_front();
            check($sformatf("out%0d_data", i), 64'(out_data(i)), 64'(e));
            $display("xfer out=%0d data=%02h", i, out_data(i));
          end
        end
        prev_out_stall[i] = bus.dout_vld[i] && !bus.dout_rd[i];
        prev_out_data[i]  = out_data(i);
      end

      s = int'(bus.din_sel);
      exp_rd = (s < NO) ? (!bus.dout_vld[s] || bus.dout_rd[s]) : 1'b1;
      check("din_rd", 64'(bus.din_rd), 64'(exp_rd));
      check("drop_cnt", 64'(bus.drop_cnt), 64'(m_drop));
      if (prev_in_stall) begin
        check("din_stable_vld", 64'(bus.din_vld), 64'd1);
        check("din_stable", 64'({bus.din_sel, bus.din_data}), 64'({prev_sel, prev_din}));
      end

      if (bus.din_vld && bus.din_rd && s < NO) exp_q[s].push_back(bus.din_data);
      if (bus.drop_clr) m_drop = (bus.din_vld && s >= NO) ? 1 : 0;
      else if (bus.din_vld && s >= NO && m_drop < 255) m_drop++;

      prev_in_stall = bus.din_vld && !bus.din_rd;
      prev_sel = bus.din_sel;
      prev_din = bus.din_data;
    end
  end

  // Presents a beat and returns #1 after the edge that accepted it.
  task automatic send(input int sel, input int data, output int waits);
    waits = 0;
    bus.din_vld  = 1'b1;
    bus.din_sel  = SW'(sel);
    bus.din_data = DW'(data);
    forever begin
      @(negedge clk);
      if (bus.din_rd) break;
      waits++;
      if (waits > 200) begin
        check("send_timeout", 64'(waits), 64'd0);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    bus.din_vld = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int w;
    logic acc;
    bus.din_vld = 1'b1; bus.din_sel = '0; bus.din_data = 8'h55;
    bus.dout_rd = '0;   bus.drop_clr = 1'b0;

    // Reset holds everything empty even with a valid beat presented.
    repeat (3) begin
      @(negedge clk);
      check("rst_vld", 64'(bus.dout_vld), 64'd0);
      check("rst_data", 64'(bus.dout_data), 64'd0);
      check("rst_drop", 64'(bus.drop_cnt), 64'd0);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    check("first_edge_vld", 64'(bus.dout_vld), 64'b001);
    check("first_edge_data", 64'(out_data(0)), 64'h55);
    bus.din_vld = 1'b0; bus.dout_rd = 3'b111;
    idle(2);

    // Routing, one cycle latency, no wait states.
    send(0, 8'h11, w); check("route0_wait", 64'(w), 0); check("route0_vld", 64'(bus.dout_vld), 64'b001);
    send(1, 8'h22, w); check("route1_wait", 64'(w), 0); check("route1_vld", 64'(bus.dout_vld), 64'b010);
    send(2, 8'h33, w); check("route2_wait", 64'(w), 0); check("route2_vld", 64'(bus.dout_vld), 64'b100);
    check("route2_data", 64'(out_data(2)), 64'h33);
    idle(1);
    check("route_done_vld", 64'(bus.dout_vld), 64'd0);

    // Backpressure on output 1 with head-of-line blocking.
    bus.dout_rd = 3'b101;
    send(1, 8'hA1, w);
    check("bp_a1_vld", 64'(bus.dout_vld[1]), 64'd1);
    bus.din_sel = SW'(1); bus.din_data = 8'hA2;
    repeat (3) begin
      @(negedge clk);
      check("bp_a2_blocked", 64'(bus.din_rd), 64'd0);
      check("bp_a1_held", 64'(out_data(1)), 64'hA1);
    end
    @(posedge clk); #1; bus.dout_rd = 3'b111;
    send(1, 8'hA2, w); check("bp_a2_data", 64'(out_data(1)), 64'hA2);
    send(0, 8'hB0, w); check("bp_b0_data", 64'(out_data(0)), 64'hB0);
    idle(2);

    // Drop path: always ready, no output activity, counter steps.
    bus.dout_rd = 3'b000;
    send(3, 8'h01, w); check("drop3_wait", 64'(w), 0); check("drop_cnt1", 64'(bus.drop_cnt), 1);
    send(7, 8'h02, w); check("drop7_wait", 64'(w), 0); check("drop_cnt2", 64'(bus.drop_cnt), 2);
    check("drop_no_vld", 64'(bus.dout_vld), 64'd0);

    // Saturation and clear.
    for (int i = 0; i < 300; i++) send(3 + (i % 5), i, w);
    idle(1);
    check("drop_sat", 64'(bus.drop_cnt), 255);
    bus.drop_clr = 1'b1;
    send(6, 8'h00, w);
    check("clr_with_drop", 64'(bus.drop_cnt), 1);
    idle(1);
    check("clr_alone", 64'(bus.drop_cnt), 0);
    bus.drop_clr = 1'b0;

    // Full throughput on output 2.
    bus.dout_rd = 3'b100;
    for (int i = 0; i < 20; i++) begin
      send(2, 8'hC0 + i, w);
      check("tput_wait", 64'(w), 0);
      check("tput_data", 64'(out_data(2)), 64'(8'hC0 + i));
    end
    idle(1);
    bus.dout_rd = 3'b111;
    idle(2);

    // Random stress.
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      acc = bus.din_vld && bus.din_rd;
      @(posedge clk); #1;
      if (!bus.din_vld || acc) begin
        bus.din_vld  = ($urandom % 4) != 0;
        bus.din_sel  = SW'($urandom % 8);
        bus.din_data = DW'($urandom);
      end
      bus.dout_rd  = NO'($urandom);
      bus.drop_clr = ($urandom % 64) == 0;
    end
    @(negedge clk);
    acc = bus.din_vld && bus.din_rd;
    @(posedge clk); #1;
    if (!acc) begin
      bus.dout_rd = 3'b111;
      repeat (3) begin @(posedge clk); #1; end
    end
    bus.drop_clr = 1'b0;
    bus.dout_rd  = 3'b111;
    idle(4);
    for (int i = 0; i < NO; i++) check($sformatf("drain_q%0d", i), 64'(exp_q[i].size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/switch_stm_demux.md
Name: switch_stm_demux

Overview:
- Handshaked stream demultiplexer: the inverse of the sel-driven switch/case multiplexer.
- Each input beat carries its own sel; the beat is routed to exactly one of OUTPUTS output streams, each behind a one-entry output register.
- sel values with no output (the "default" branch) are consumed and dropped, and a saturating counter records them.
- Sits between a single producer and OUTPUTS independent consumers in the statements/stream examples.

Parameters:
- DATA_WIDTH, 8: width of the data payload.
- OUTPUTS, 3: number of output streams; legal range 2..8.
- SEL_WIDTH, 3: width of sel; must satisfy 2**SEL_WIDTH >= OUTPUTS.
- DROP_CNT_WIDTH, 8: width of the saturating drop counter.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- din_data  input  DATA_WIDTH  input payload.
- din_sel  input  SEL_WIDTH  destination index, qualified by din_vld.
- din_vld  input  1  input beat valid.
- din_rd  output  1  input ready; a beat transfers when din_vld && din_rd.
- dout_data  output  OUTPUTS*DATA_WIDTH  payload of output i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- dout_vld  output  OUTPUTS  per-output valid.
- dout_rd  input  OUTPUTS  per-output ready.
- drop_cnt  output  DROP_CNT_WIDTH  number of dropped beats, saturating.
- drop_clr  input  1  synchronous clear of drop_cnt.

Behaviour:
- Reset (asynchronous, rst_n=0): all dout_vld=0, all dout_data=0, drop_cnt=0. Exiting reset needs no extra cycle; beats are accepted on the first clock edge with rst_n=1.
- A reset mid-operation discards all held beats. No partial transfer survives.
- Each output i has a register slot (vld_q[i], data_q[i]), which drives dout_vld[i] and dout_data[i] directly. No combinational path from din to dout.
- Legal beat (din_sel < OUTPUTS), target t = din_sel:
  - din_rd = !vld_q[t] || dout_rd[t].
  - On transfer: data_q[t] <= din_data and vld_q[t] <= 1.
  - Latency is 1 cycle from input transfer to dout_vld[t].
- Output drain: when vld_q[i] && dout_rd[i] and no new beat is loaded into slot i, vld_q[i] <= 0.
- Load and drain of the same slot in the same cycle: the new beat replaces the old one and vld stays 1. This gives full throughput of 1 beat/cycle per output.
- Illegal beat (din_sel >= OUTPUTS): din_rd=1 unconditionally, the beat is consumed, no output changes, and drop_cnt increments.
- drop_cnt saturates at all-ones and never wraps.
- drop_clr=1 sets drop_cnt to 0. If a drop occurs in the same cycle, drop_cnt becomes 1 (clear first, then count).
- din_rd depends combinationally on din_sel, din_vld-independent state and dout_rd. din_vld must not influence din_rd.
- Independent outputs: a stalled output never blocks beats addressed to other outputs. Only a beat targeting the stalled output waits at the input (head-of-line, by design).
- Data stability: while dout_vld[i]=1 and dout_rd[i]=0, dout_data[i] holds constant.
- Ordering: beats to the same output leave in arrival order. No ordering guarantee across outputs.
- Assertions (bench): din_data and din_sel must stay stable while din_vld && !din_rd.

Decomposition:
- Shared package:
  - function computing the minimum SEL_WIDTH for OUTPUTS (clog2);
  - DROP_CNT_MAX constant derivation;
  - a constant for the reset data value (0).
- Natural sub-module: stream_reg_slice, a one-entry DATA_WIDTH register with vld/rd handshake and load-while-drain. Instantiate it OUTPUTS times via generate.
- The top level keeps the sel decode, the din_rd mux and the drop counter.

Test Plan:
- Reset check: hold rst_n=0 with din_vld=1 → dout_vld=000, drop_cnt=0, and nothing is captured. Release rst_n; the next beat is accepted on the first edge.
- Routing: din_sel=0,1,2 with data 0x11,0x22,0x33 back to back, all dout_rd=1 → one cycle later each dout_vld[i] pulses for one cycle with the matching data, and din_rd stays 1 throughout.
- Backpressure: dout_rd[1]=0, send 0xA1 then 0xA2 to sel=1, then 0xB0 to sel=0 →
  - 0xA1 is held on output 1;
  - din_rd=0 while 0xA2 is presented;
  - 0xB0 cannot pass while 0xA2 is stalled ahead of it (head-of-line, by design);
  - raising dout_rd[1] releases 0xA1, then 0xA2, then 0xB0 appears on output 0.
- Drop path: din_sel=3 and 7 with dout_rd all 0 → din_rd=1, no dout_vld change, drop_cnt goes 0→1→2.
- Saturation and clear: issue 300 illegal beats → drop_cnt=255. Assert drop_clr together with one illegal beat → drop_cnt=1. drop_clr alone → 0.
- Full throughput and random stress: continuous beats to sel=2 with dout_rd[2]=1 → one beat per cycle with no bubbles. Then random vld/rd/sel (including illegal values) over 10k cycles → scoreboard shows in-order delivery per output and drop_cnt equal to the number of illegal transfers.
